// File: rtl/cbus_sram_responder_pkg.sv
// Shared cache-bus types for the SRAM responder and its address generator.
package cbus_sram_responder_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [7:0]  mlen_t;   // beats - 1
  typedef logic [2:0]  msize_t;

  localparam mlen_t MLEN1   = 8'd0;
  localparam mlen_t MLEN2   = 8'd1;
  localparam mlen_t MLEN4   = 8'd3;
  localparam mlen_t MLEN8   = 8'd7;
  localparam mlen_t MLEN16  = 8'd15;
  localparam mlen_t MLEN256 = 8'd255;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'd0,
    BURST_INCR     = 2'd1,
    BURST_WRAP     = 2'd2,
    BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RLAT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    DONE   = 3'd4
  } cbus_resp_state_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam int CBUS_REQ_W  = $bits(cbus_req_t);
  localparam int CBUS_RESP_W = $bits(cbus_resp_t);

  // Address of the following beat; WRAP windows are (len+1)*8 bytes, len+1 a power of two.
  function automatic addr_t cbus_next_addr(addr_t a, axi_burst_type_t b, mlen_t l);
    addr_t inc;
    addr_t mask;
    addr_t res;
    inc  = a + 64'd8;
    mask = ((addr_t'(l) + 64'd1) << 3) - 64'd1;
    case (b)
      BURST_FIXED: res = a;
      BURST_WRAP:  res = (a & ~mask) | (inc & mask);
      default:     res = inc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cbus_burst_addr_gen.sv
// Current burst address and beat counter, with load/advance controls.
module cbus_burst_addr_gen
  import cbus_sram_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_len,
  input  logic [1:0]  load_burst,
  output logic [63:0] cur_addr,
  output logic        is_last,
  output logic        next_is_last
);

  logic [7:0]      beat;
  logic [7:0]      len_q;
  axi_burst_type_t burst_q;

  // Latch the burst descriptor on load, step address and beat on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr <= '0;
      beat     <= '0;
      len_q    <= '0;
      burst_q  <= BURST_FIXED;
    end else if (load) begin
      cur_addr <= load_addr;
      beat     <= '0;
      len_q    <= load_len;
      burst_q  <= axi_burst_type_t'(load_burst);
    end else if (advance) begin
      cur_addr <= cbus_next_addr(cur_addr, burst_q, len_q);
      beat     <= beat + 8'd1;
    end
  end

  assign is_last      = (beat == len_q);
  assign next_is_last = (({1'b0, beat} + 9'd1) == {1'b0, len_q});

endmodule

// File: rtl/cbus_sram_responder.sv
// Cache-bus responder backed by a word-wide single-port SRAM.
// Optional random ready stalls: define CBUS_RESP_RANDOM_STALL_EN.
//
// state  | meaning
// IDLE   | waiting for creq.valid
// RLAT   | read latency countdown, first SRAM read issued at its end
// RBURST | one read beat per cycle
// WBURST | one write beat per ready cycle
// DONE   | single dead cycle after the last beat
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CBUS_REQ_W-1:0]  creq,
  output logic [CBUS_RESP_W-1:0] cresp
);

  cbus_req_t        req;
  cbus_resp_t       resp;
  cbus_resp_state_t state, state_nxt;
  logic             ready_q, last_q, ready_nxt, last_nxt;
  logic [63:0]      rdata;
  logic             load, advance, we, re, stall_nxt;
  logic [1:0]       lat_cnt;
  logic [63:0]      cur_addr;
  logic             is_last, next_is_last;
  logic [DEPTH_LOG2-1:0] widx;
  logic [63:0]      mem [0:(1<<DEPTH_LOG2)-1];
  logic             unused_bits;

  assign req         = cbus_req_t'(creq);
  assign widx        = cur_addr[DEPTH_LOG2+2:3];
  assign unused_bits = ^{req.size, cur_addr[63:DEPTH_LOG2+3], cur_addr[2:0]};

  assign resp.ready = ready_q;
  assign resp.last  = last_q;
  assign resp.data  = rdata;
  assign cresp      = resp;

  cbus_burst_addr_gen u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .advance      (advance),
    .load_addr    (req.addr),
    .load_len     (req.len),
    .load_burst   (req.burst),
    .cur_addr     (cur_addr),
    .is_last      (is_last),
    .next_is_last (next_is_last)
  );

`ifdef CBUS_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  // Free-running LFSR; a 00 in its low bits marks the coming cycle as a stall.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_nxt;
  end
  assign stall_nxt = (lfsr_nxt[1:0] == 2'b00);
`else
  assign stall_nxt = 1'b0;
`endif

  // State, registered response flags and read-latency down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      last_q  <= last_nxt;
      if (load)                            lat_cnt <= 2'(READ_LAT - 1);
      else if (state == RLAT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
    end
  end

  // Next state, next response flags and SRAM/address-generator strobes.
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b0;
    last_nxt  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    case (state)
      IDLE: begin
        if (req.valid) begin
          load = 1'b1;
          if (req.is_write) begin
            state_nxt = WBURST;
            ready_nxt = !stall_nxt;
            last_nxt  = !stall_nxt && (req.len == MLEN1);
          end else begin
            state_nxt = RLAT;
          end
        end
      end
      RLAT: begin
        if (!req.valid) begin
          state_nxt = IDLE;
        end else if (lat_cnt == 2'd0) begin
          state_nxt = RBURST;
          if (!stall_nxt) begin
            re        = 1'b1;
            advance   = 1'b1;
            ready_nxt = 1'b1;
            last_nxt  = is_last;
          end
        end
      end
      RBURST: begin
        if (!req.valid) begin
          state_nxt = IDLE;
        end else if (ready_q && last_q) begin
          state_nxt = DONE;
        end else if (!stall_nxt) begin
          re        = 1'b1;
          advance   = 1'b1;
          ready_nxt = 1'b1;
          last_nxt  = is_last;
        end
      end
      WBURST: begin
        if (!req.valid) begin
          state_nxt = IDLE;
        end else if (ready_q) begin
          we      = 1'b1;
          advance = 1'b1;
          if (last_q) begin
            state_nxt = DONE;
          end else if (!stall_nxt) begin
            ready_nxt = 1'b1;
            last_nxt  = next_is_last;
          end
        end else if (!stall_nxt) begin
          ready_nxt = 1'b1;
          last_nxt  = is_last;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-port SRAM with byte enables; the read register is the response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (req.strobe[i]) mem[widx][8*i +: 8] <= req.data[8*i +: 8];
        end
      end
      if (re) rdata <= mem[widx];
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Self-checking bench: directed cases plus random bursts against a word-array model.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int RL    = 1;
  localparam int DL2   = 8;
  localparam int WORDS = 1 << DL2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  req;
  cbus_resp_t resp;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_mem [WORDS];
  logic [63:0] wdata [256];
  logic [7:0]  wstrb [256];

  cbus_sram_responder #(.DEPTH_LOG2(DL2), .READ_LAT(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (req),
    .cresp (resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Word index touched by beat k, from plain byte-address arithmetic.
  function automatic int exp_word(logic [63:0] a, int len, logic [1:0] burst, int k);
    logic [63:0] sz, base, off, ea;
    case (burst)
      2'd0: ea = a;
      2'd2: begin
        sz   = 64'(len + 1) * 64'd8;
        base = a - (a % sz);
        off  = ((a % sz) + 64'(k) * 64'd8) % sz;
        ea   = base + off;
      end
      default: ea = a + 64'(k) * 64'd8;
    endcase
    return int'((ea >> 3) % 64'(WORDS));
  endfunction

  // One transaction; cut >= 0 drops valid (or pulses reset) once cut beats were seen.
  task automatic run_txn(input bit wr, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input bit keep_valid,
                         input int cut, input bit cut_rst);
    int k, cyc, prev, nw, idx;
    bit done, cut_armed;
    k = 0; cyc = 0; prev = 0; done = 0; cut_armed = 0;
    @(posedge clk); #1;
    req.valid    = 1'b1;
    req.is_write = wr;
    req.size     = 3'd3;
    req.addr     = addr;
    req.len      = 8'(len);
    req.burst    = axi_burst_type_t'(burst);
    req.data     = wdata[0];
    req.strobe   = wstrb[0];
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (wr && k <= len) begin
        req.data   = wdata[k];
        req.strobe = wstrb[k];
      end
      if (cut_armed) begin
        chk("cut_ready", 64'(resp.ready), 64'd0);
        chk("cut_last", 64'(resp.last), 64'd0);
        reset     = 1'b0;
        req.valid = 1'b0;
        done      = 1;
      end else if (k > len) begin
        chk("done_ready", 64'(resp.ready), 64'd0);
        if (!keep_valid) req.valid = 1'b0;
        done = 1;
      end else if (cut >= 0 && k == cut) begin
        if (cut_rst) reset = 1'b1;
        else         req.valid = 1'b0;
        cut_armed = 1;
      end else if (resp.ready) begin
        if (k == 0) chk("first_lat", 64'(cyc), wr ? 64'd1 : 64'(1 + RL));
        else        chk("no_bubble", 64'(cyc), 64'(prev + 1));
        chk("last_flag", 64'(resp.last), 64'(k == len));
        if (!wr) chk("rd_data", resp.data, model_mem[exp_word(addr, len, burst, k)]);
        prev = cyc;
        k++;
      end
    end
    if (!done) chk("timeout", 64'd0, 64'd1);
    if (wr) begin
      nw = (cut >= 0) ? cut : len + 1;
      for (int b = 0; b < nw; b++) begin
        idx = exp_word(addr, len, burst, b);
        for (int i = 0; i < 8; i++)
          if (wstrb[b][i]) model_mem[idx][8*i +: 8] = wdata[b][8*i +: 8];
      end
    end
  endtask

  initial begin
    req   = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(resp.ready), 64'd0);
    chk("rst_last", 64'(resp.last), 64'd0);
    chk("rst_data", resp.data, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      wdata[i] = 64'(i);
      wstrb[i] = 8'hFF;
    end
    run_txn(1, 64'h0, 255, 2'd1, 0, -1, 0);

    run_txn(0, 64'h8000_0040, 3, 2'd1, 0, -1, 0);
    run_txn(0, 64'h8000_0050, 3, 2'd2, 0, -1, 0);

    wdata[0] = 64'h1111_2222_3333_4444; wstrb[0] = 8'hFF;
    wdata[1] = 64'hAAAA_BBBB_CCCC_DDDD; wstrb[1] = 8'h0F;
    run_txn(1, 64'h100, 1, 2'd1, 0, -1, 0);
    run_txn(0, 64'h100, 1, 2'd1, 0, -1, 0);

    for (int i = 0; i < 8; i++) begin
      wdata[i] = {$urandom, $urandom};
      wstrb[i] = 8'hFF;
    end
    run_txn(1, 64'h400, 7, 2'd1, 0, 2, 0);
    run_txn(0, 64'h400, 7, 2'd1, 0, -1, 0);

    run_txn(0, 64'h200, 15, 2'd1, 0, 2, 1);
    @(posedge clk); #1;
    run_txn(0, 64'h318, 3, 2'd1, 0, -1, 0);

    run_txn(0, 64'h40, 3, 2'd1, 1, -1, 0);
    run_txn(0, 64'h7F8, 2, 2'd1, 1, -1, 0);
    run_txn(0, 64'h60, 7, 2'd2, 0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      bit          w;
      int          ln;
      logic [1:0]  b;
      logic [63:0] a;
      w = 1'($urandom_range(0, 1));
      b = 2'($urandom_range(0, 3));
      if (b == 2'd2) ln = (1 << $urandom_range(0, 4)) - 1;
      else           ln = int'($urandom_range(0, 20));
      a = {$urandom, $urandom};
      for (int i = 0; i <= ln; i++) begin
        wdata[i] = {$urandom, $urandom};
        wstrb[i] = 8'($urandom);
      end
      run_txn(w, a, ln, b, 1'($urandom_range(0, 1)), -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Responder (slave) end of the simplified burst cache bus: accepts cbus_req_t transactions from a cache/arbiter and answers with cbus_resp_t beats, backed by an internal word-wide synchronous SRAM array.
- Serves as the memory model behind the I/D caches in simulation.
- Serves as an on-chip scratch memory in FPGA builds.
- Supports FIXED, INCR and WRAP bursts of up to 256 beats, byte strobes, and one-beat-per-cycle streaming.

Parameters:
- DEPTH_LOG2, 16, log2 of the number of 64-bit words in the array (default 512 KiB).
- READ_LAT, 1, extra cycles between accepting a read and the first ready beat (legal values 1..4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- creq  input  $bits(cbus_req_t)  request from master: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  output  $bits(cbus_resp_t)  response: ready, last, data.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset. All outputs are registered.
- Reset values: cresp.ready=0, cresp.last=0, cresp.data=0, state=IDLE, beat counter=0. Memory contents are not reset.
- States: IDLE, RLAT, RBURST, WBURST, DONE.
- IDLE, creq.valid=1 at cycle T:
  - Latch addr, len, burst, is_write; beat counter=0.
  - Go to RLAT if read, WBURST if write.
- RLAT: counts READ_LAT cycles, issuing the SRAM read of the current address; then go to RBURST. The first read beat (ready=1) appears at T+1+READ_LAT.
- RBURST:
  - One beat per cycle: ready=1, data=mem[cur].
  - The next address is issued concurrently, so there are no bubbles.
  - last=1 exactly on beat len.
- WBURST:
  - ready=1 each cycle starting T+1.
  - mem[cur] is written with creq.data under creq.strobe (byte i written iff strobe[i]) in the same cycle ready=1.
  - The master presents the next beat's data in the cycle after ready. last=1 on beat len.
- DONE:
  - Entered after the last beat; lasts exactly one cycle with ready=0, and creq.valid is ignored.
  - Then go to IDLE. A new transaction is therefore accepted no earlier than 2 cycles after the last beat.
- Word index = addr[DEPTH_LOG2+2:3]. addr[2:0] is ignored (data is always word-aligned). Upper address bits are ignored, so addresses alias modulo the array size.
- Address update per beat:
  - FIXED: unchanged.
  - INCR (and RESERVED): +8.
  - WRAP: +8 within a window of (len+1)*8 bytes aligned to that size; the low log2(len+1)+3 bits wrap, and the upper bits are held.
- creq.size is not interpreted; all beats are 8 bytes and the strobe selects the bytes.
- creq.valid dropping mid-burst (RLAT/RBURST/WBURST): abort next cycle to IDLE with ready=0. No further writes occur, and already-written beats persist.
- reset mid-burst: IDLE next cycle, ready=0, no write performed in the reset cycle.
- Request fields other than data/strobe changing mid-burst is master error; the latched copies are used.

Optional Feature:
- Macro: CBUS_RESP_RANDOM_STALL_EN.
- When defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset) advances every cycle.
  - In RBURST/WBURST, any cycle with lfsr[1:0]==2'b00 is a stall: ready=0, no address advance, no write.
  - This exercises master wait handling.
- When undefined: no LFSR, no stalls; timing is exactly as above.

Decomposition:
- Add to package common:
  - typedef enum cbus_resp_state_t {IDLE,RLAT,RBURST,WBURST,DONE}.
  - Function cbus_next_addr(addr_t a, axi_burst_type_t b, mlen_t l) returning addr_t, shared with caches' refill counters.
- Sub-module cbus_burst_addr_gen: holds the current address and beat counter, computes next-address and last, with load/advance inputs.
- The SRAM array stays inline, inferred as a single-port RAM with byte enables.

Test Plan:
- INCR read, len=MLEN4, addr=0x80000040, mem preloaded with word index i -> 4 ready beats starting T+2 (READ_LAT=1), data i=8,9,10,11, last only on the 4th, then DONE one cycle.
- WRAP read, len=MLEN4, addr=0x80000050 -> beats from word indices 10,11,8,9; last on the 4th.
- INCR write, len=MLEN2, addr=0x100, data 64'h1111_2222_3333_4444 strobe 8'hFF, then 64'hAAAA_BBBB_CCCC_DDDD strobe 8'h0F -> mem[0x20]=1111_2222_3333_4444. mem[0x21] low 32 bits=CCCC_DDDD, upper bits unchanged.
- Valid dropped after beat 2 of an MLEN8 write -> only 2 words written, ready=0 next cycle, state IDLE.
- Reset asserted during beat 3 of an MLEN16 read -> ready=0 and last=0 the next cycle. A new read issued 1 cycle after reset release is served correctly from its own address.
- Back-to-back: valid held high after last -> no ready in the DONE cycle, second transaction accepted in the following IDLE cycle.
